// File: rtl/riscv_pkg.sv
// Shared load/store encodings, access-size decode and bridge FSM states.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Unused encodings (011/110/111) fall through to word accesses.
    function automatic size_e decode_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: decode_size = SZ_B;
            F3_H, F3_HU: decode_size = SZ_H;
            default:     decode_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store lane replication,
// misalignment detection and load extract/extend.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misalign,
    output logic [31:0] rdata_ext
);

    size_e       size;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        zext;

    assign size  = decode_size(funct3);
    assign zext  = funct3[2];
    assign rbyte = rword[{offset, 3'b000} +: 8];
    assign rhalf = offset[1] ? rword[31:16] : rword[15:0];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        misalign   = 1'b0;
        rdata_ext  = rword;
        case (size)
            SZ_B: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{rbyte[7] & ~zext}}, rbyte};
            end
            SZ_H: begin
                be         = 4'b0011 << {offset[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                misalign   = offset[0];
                rdata_ext  = {{16{rhalf[15] & ~zext}}, rhalf};
            end
            default: begin
                misalign = |offset;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_bridge.sv
// Load/store bridge: stalls the core while a req/ack bus transaction
// runs, with timeout abort and sign/zero-extended load return.
module data_mem_bridge
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_e      state;
    logic [7:0]  wait_cnt;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;
    logic        op_load;

    logic [2:0]  sel_f3;
    logic [1:0]  sel_off;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        lane_misalign;
    logic        core_req;
    logic        accept;

    // In IDLE the live request is decoded; afterwards the latched one drives extraction.
    assign sel_f3   = (state == ST_IDLE) ? funct3    : op_f3;
    assign sel_off  = (state == ST_IDLE) ? addr[1:0] : op_off;

    assign core_req = mem_read | mem_write;
    assign accept   = (state == ST_IDLE) && core_req && !lane_misalign;
    assign misalign = (state == ST_IDLE) && core_req && lane_misalign;
    assign stall    = accept || (state == ST_REQ);

    lsu_align u_align (
        .funct3     (sel_f3),
        .offset     (sel_off),
        .wdata      (wdata),
        .rword      (bus_rdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .misalign   (lane_misalign),
        .rdata_ext  (load_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            op_f3     <= '0;
            op_off    <= '0;
            op_load   <= 1'b0;
            rdata     <= '0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_REQ;
                        wait_cnt  <= '0;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wdata <= lane_wdata;
                        bus_be    <= lane_be;
                        op_f3     <= funct3;
                        op_off    <= addr[1:0];
                        op_load   <= ~mem_write;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        state   <= ST_DONE;
                        bus_req <= 1'b0;
                        if (op_load) begin
                            rdata <= load_data;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        state   <= ST_DONE;
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        rdata   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    bus_err <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed scoreboard bench for data_mem_bridge (TIMEOUT = 4).
module tb_data_mem_bridge;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misalign, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] last_rdata;
    int          total  = 0;
    int          passed = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    data_mem_bridge #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: ref_be = (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 :
                                     (off == 2'd2) ? 4'b0100 : 4'b1000;
            3'b001, 3'b101: ref_be = off[1] ? 4'b1100 : 4'b0011;
            default:        ref_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000, 3'b100: ref_wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'b001, 3'b101: ref_wdata = {d[15:0], d[15:0]};
            default:        ref_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] sh;
        logic [15:0] h;
        sh = w >> (8 * int'(off));
        h  = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  ref_load = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ref_load = {24'h0, sh[7:0]};
            3'b001:  ref_load = {{16{h[15]}}, h};
            3'b101:  ref_load = {16'h0, h};
            default: ref_load = w;
        endcase
    endfunction

    // ack_wait < 0 means memory never answers (timeout expected).
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int ack_wait,
                              input logic [31:0] word);
        bus_exp_t    be_exp;
        bus_exp_t    got;
        logic [31:0] rexp;
        int          stall_cycles = 0;
        int          req_cycles   = 0;
        bit          seen = 0;
        bit          done = 0;

        be_exp.addr  = {a[31:2], 2'b00};
        be_exp.wdata = ref_wdata(f3, wd);
        be_exp.be    = ref_be(f3, a[1:0]);
        be_exp.we    = wr;
        bus_q.push_back(be_exp);
        if (ack_wait < 0)      last_rdata = 32'h0;
        else if (!wr)          last_rdata = ref_load(f3, a[1:0], word);
        rd_q.push_back(last_rdata);

        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        #1;
        chk({tag, "_stall_c0"}, {31'b0, stall}, 32'd1);
        if (stall) stall_cycles++;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (bus_req) begin
                if (!seen) begin
                    got = bus_q.pop_front();
                    chk({tag, "_bus_addr"},  bus_addr,  got.addr);
                    chk({tag, "_bus_wdata"}, bus_wdata, got.wdata);
                    chk({tag, "_bus_be"},    {28'b0, bus_be}, {28'b0, got.be});
                    chk({tag, "_bus_we"},    {31'b0, bus_we}, {31'b0, got.we});
                    seen = 1;
                end
                if (req_cycles == ack_wait) begin
                    bus_ack   = 1'b1;
                    bus_rdata = word;
                end
                req_cycles++;
            end
            if (stall) stall_cycles++;
            else done = 1;
        end
        if (!done) chk({tag, "_done_budget"}, 32'd0, 32'd1);
        rexp = rd_q.pop_front();
        chk({tag, "_rdata"},   rdata, rexp);
        chk({tag, "_bus_err"}, {31'b0, bus_err}, {31'b0, ack_wait < 0});
        chk({tag, "_stall_cycles"}, 32'(stall_cycles),
            (ack_wait < 0) ? 32'(TMO + 1) : 32'(ack_wait + 2));
        chk({tag, "_req_cycles"}, 32'(req_cycles),
            (ack_wait < 0) ? 32'(TMO) : 32'(ack_wait + 1));
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk({tag, "_err_clear"}, {31'b0, bus_err}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0; last_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata",     rdata, 32'h0);
        chk("rst_stall",     {31'b0, stall}, 32'd0);
        chk("rst_bus_req",   {31'b0, bus_req}, 32'd0);
        chk("rst_bus_err",   {31'b0, bus_err}, 32'd0);
        chk("rst_bus_we",    {31'b0, bus_we}, 32'd0);
        chk("rst_bus_addr",  bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_be",    {28'b0, bus_be}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_access("sw",   1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0);
        run_access("sb",   1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0);
        run_access("lb",   1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 0, 32'h12F4_5678);
        run_access("lbu",  1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 2, 32'h12F4_5678);
        chk("lbu_const", rdata, 32'h0000_00F4);
        run_access("sh",   1'b0, 1'b1, 3'b001, 32'h0000_0106, 32'h0000_1234, 0, 32'h0);
        run_access("lhu",  1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 0, 32'h8001_7777);
        run_access("lh",   1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0, 1, 32'h1111_9ABC);
        run_access("rwst", 1'b1, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_0077, 0, 32'h5555_5555);
        run_access("f3_11", 1'b1, 1'b0, 3'b011, 32'h0000_0308, 32'h0, 0, 32'hCAFE_F00D);

        // Misaligned LH: no bus activity, rdata untouched.
        mem_read = 1'b1; funct3 = 3'b001; addr = 32'h0000_0101;
        #1;
        chk("mis_flag",  {31'b0, misalign}, 32'd1);
        chk("mis_stall", {31'b0, stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mis_bus_req", {31'b0, bus_req}, 32'd0);
        end
        chk("mis_rdata", rdata, last_rdata);
        mem_read = 1'b0;

        run_access("lw_tmo", 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, -1, 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        #1;
        chk("stray_rdata",   rdata, 32'h0);
        chk("stray_bus_req", {31'b0, bus_req}, 32'd0);
        chk("stray_stall",   {31'b0, stall}, 32'd0);

        // Load something nonzero, then reset in the middle of the next access.
        run_access("lw_pre", 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 0, 32'h1357_2468);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0504;
        @(posedge clk); #1;
        chk("mid_in_req", {31'b0, bus_req}, 32'd1);
        #2;
        reset = 1'b0; mem_read = 1'b0;
        #1;
        chk("mid_req_drop", {31'b0, bus_req}, 32'd0);
        chk("mid_stall",    {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        chk("late_ack_rdata", rdata, 32'h0);
        chk("late_ack_req",   {31'b0, bus_req}, 32'd0);
        chk("late_ack_err",   {31'b0, bus_err}, 32'd0);

        run_access("post_rst", 1'b1, 1'b0, 3'b000, 32'h0000_0601, 32'h0, 0, 32'h0000_8000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
